// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT controller with a small return-address
// stack that drives program_counter inc/branch controls in the same cycle.
module pc_sequencer #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic                      halt_req,
    input  logic                      stall,
    input  logic                      br_req,
    input  logic                      br_taken,
    input  logic [ADDR_W-1:0]         br_target,
    input  logic                      call_req,
    input  logic                      ret_req,
    input  logic [ADDR_W-1:0]         current_addr,
    output logic                      inc,
    output logic                      branch_en,
    output logic [ADDR_W-1:0]         branch_addr,
    output logic                      running,
    output logic [$clog2(DEPTH):0]    stack_depth,
    output logic                      err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DEP_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [DEP_W-1:0] DEPTH_FULL = DEP_W'(DEPTH);
    localparam logic [DEP_W-1:0] DEPTH_ONE  = DEP_W'(1);

    logic [1:0]        state_q, state_d;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];

    logic [DEP_W-1:0]  depth_m1_s;
    logic [ADDR_W-1:0] top_s;

    // Top-of-stack read; depth 0 selects a don't-care entry that is never used.
    always_comb begin
        depth_m1_s = depth_q - DEPTH_ONE;
        top_s      = stack_q[depth_m1_s[PTR_W-1:0]];
    end

    // Next-state, stack update and same-cycle program_counter controls.
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        err_d       = err_q;
        stack_d     = stack_q;
        inc         = 1'b0;
        branch_en   = 1'b0;
        branch_addr = {ADDR_W{1'b0}};
        if (rst) begin
            state_d = ST_IDLE;
            depth_d = {DEP_W{1'b0}};
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        branch_en   = 1'b1;
                        branch_addr = start_addr;
                        depth_d     = {DEP_W{1'b0}};
                        state_d     = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (stall) begin
                        state_d = ST_RUN;
                    end else if (ret_req) begin
                        if (depth_q != {DEP_W{1'b0}}) begin
                            branch_en   = 1'b1;
                            branch_addr = top_s;
                            depth_d     = depth_m1_s;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    end else if (call_req) begin
                        if (depth_q != DEPTH_FULL) begin
                            branch_en   = 1'b1;
                            branch_addr = br_target;
                            stack_d[depth_q[PTR_W-1:0]] = current_addr + ADDR_W'(1);
                            depth_d     = depth_q + DEPTH_ONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    end else if (br_req && br_taken) begin
                        branch_en   = 1'b1;
                        branch_addr = br_target;
                    end else begin
                        inc = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, stack depth, sticky error and stack storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            depth_q <= {DEP_W{1'b0}};
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign running     = (state_q == ST_RUN);
    assign stack_depth = depth_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural program_counter closes the loop, and a
// vector table plus a stall sequence is checked through an expectation queue.
module tb_pc_sequencer;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, start, halt_req, stall, br_req, br_taken, call_req, ret_req;
    logic [ADDR_W-1:0] start_addr, br_target, pc;
    logic              inc, branch_en, running, err;
    logic [ADDR_W-1:0] branch_addr;
    logic [2:0]        stack_depth;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int rst, start, saddr, halt, stall, br, tk, tgt, call, ret;
        int e_inc, e_br, e_addr, e_pc, e_run, e_dep, e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .halt_req(halt_req), .stall(stall), .br_req(br_req), .br_taken(br_taken),
        .br_target(br_target), .call_req(call_req), .ret_req(ret_req),
        .current_addr(pc), .inc(inc), .branch_en(branch_en), .branch_addr(branch_addr),
        .running(running), .stack_depth(stack_depth), .err(err)
    );

    always #5 clk = ~clk;

    initial pc = '0;

    // Behavioural program_counter driven by the sequencer controls.
    always_ff @(posedge clk) begin
        if (branch_en) pc <= branch_addr;
        else if (inc)  pc <= pc + 11'd1;
    end

    function automatic vec_t mk(int r, int s, int sa, int h, int st, int b, int t, int tg,
                                int c, int rt, int ei, int eb, int ea, int ep, int er,
                                int ed, int ee);
        vec_t v;
        v.rst = r; v.start = s; v.saddr = sa; v.halt = h; v.stall = st; v.br = b;
        v.tk = t; v.tgt = tg; v.call = c; v.ret = rt; v.e_inc = ei; v.e_br = eb;
        v.e_addr = ea; v.e_pc = ep; v.e_run = er; v.e_dep = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst[0]; start = v.start[0]; start_addr = ADDR_W'(v.saddr);
        halt_req = v.halt[0]; stall = v.stall[0]; br_req = v.br[0]; br_taken = v.tk[0];
        br_target = ADDR_W'(v.tgt); call_req = v.call[0]; ret_req = v.ret[0];
        exp_q.push_back(v);
        #2;
        check("inc",         int'(inc),         exp_q[0].e_inc);
        check("branch_en",   int'(branch_en),   exp_q[0].e_br);
        check("branch_addr", int'(branch_addr), exp_q[0].e_addr);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pc",          int'(pc),          e.e_pc);
        check("running",     int'(running),     e.e_run);
        check("stack_depth", int'(stack_depth), e.e_dep);
        check("err",         int'(err),         e.e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start_addr = '0; halt_req = 1'b0; stall = 1'b0;
        br_req = 1'b0; br_taken = 1'b0; br_target = '0; call_req = 1'b0; ret_req = 1'b0;
        //           rst st sa  h  st b  t tgt c  r   inc br addr pc  run dep err
        tbl.push_back(mk(1, 1, 100, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0,   0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0,   0, 0,  0, 0, 0,   0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 100, 0, 0, 0, 0, 0,   0, 0,  0, 1, 100, 100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   101, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   102, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 50,  0, 0,  0, 1, 50,  50,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 300, 1, 0,  0, 1, 300, 300, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   301, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   302, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   303, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 1,  0, 1, 51,  51,  1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 20, 0, 0, 0, 0, 0,   51,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 20,  0, 0,  0, 1, 20,  20,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 76,  0, 0,  0, 1, 76,  76,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 200, 1, 0,  0, 1, 200, 200, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 1, 500, 1, 1,  0, 1, 77,  77,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1, 0, 900, 0, 0,  1, 0, 0,   78,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 10,  1, 0,  0, 1, 10,  10,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 20,  1, 0,  0, 1, 20,  20,  1, 2, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 30,  1, 0,  0, 1, 30,  30,  1, 3, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 40,  1, 0,  0, 1, 40,  40,  1, 4, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 99,  1, 0,  0, 0, 0,   40,  0, 4, 1));
        tbl.push_back(mk(0, 1, 0,   0, 0, 0, 0, 0,   0, 0,  0, 1, 0,   0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0,   1, 0, 1, 1, 9,   0, 0,  0, 0, 0,   0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  0, 0, 0,   0,   0, 0, 1));
        tbl.push_back(mk(0, 1, 5,   0, 0, 0, 0, 0,   0, 0,  0, 1, 5,   5,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 600, 1, 0,  0, 1, 600, 600, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 700, 1, 0,  0, 1, 700, 700, 1, 2, 1));
        tbl.push_back(mk(1, 0, 0,   0, 1, 0, 0, 800, 1, 0,  0, 0, 0,   700, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  0, 0, 0,   700, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2047, 0, 0, 0, 0, 0,  0, 0,  0, 1, 2047, 2047, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 10,  1, 0,  0, 1, 10,  10,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 1,  0, 1, 0,   0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0, 1,  0, 0, 0,   0,   0, 0, 1));
        tbl.push_back(mk(0, 1, 3,   0, 0, 0, 0, 0,   0, 0,  0, 1, 3,   3,   1, 0, 1));
        tbl.push_back(mk(0, 1, 9,   0, 0, 0, 0, 0,   0, 0,  1, 0, 0,   4,   1, 0, 1));

        foreach (tbl[i]) step(tbl[i]);

        // Stall of random length holding a taken branch, then release.
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++)
            step(mk(0, 0, 0, 0, 1, 1, 1, 33, 0, 0, 0, 0, 0, 4, 1, 0, 1));
        step(mk(0, 0, 0, 0, 0, 1, 1, 33, 0, 0, 0, 1, 33, 33, 1, 0, 1));
        step(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  33, 0, 0, 1));

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expectations left over, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
